// File: rtl/hormado_pkg.sv
// Shared definitions for the shaping-station arbiter: material codes,
// output bin indices and FSM state encoding.
package hormado_pkg;

  localparam int NUM_BINS = 5;

  // One-hot material codes carried on mat_lo / mat_hi.
  localparam logic [2:0] MAT_COT = 3'b001;
  localparam logic [2:0] MAT_POL = 3'b010;
  localparam logic [2:0] MAT_ACR = 3'b100;

  // Bit positions in the one-hot destination bin vector.
  localparam int BIN_LO_COT = 0;
  localparam int BIN_LO_POL = 1;
  localparam int BIN_LO_ACR = 2;
  localparam int BIN_HI_COT = 3;
  localparam int BIN_HI_ACR = 4;

  typedef logic [NUM_BINS-1:0] bin_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FORM = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/hormado_if.sv
// Handshake bundle between the two sealers / bin counters (master side)
// and the shaping-station arbiter (slave side).
interface hormado_if;
  import hormado_pkg::*;

  logic       req_lo;
  logic [2:0] mat_lo;
  logic       req_hi;
  logic [2:0] mat_hi;
  bin_t       bin_full;
  logic       done_rdy;
  logic       gnt_lo;
  logic       gnt_hi;
  logic       reject_lo;
  logic       reject_hi;
  logic       form_en;
  logic       done_vld;
  bin_t       done_bin;

  modport master (
    output req_lo, mat_lo, req_hi, mat_hi, bin_full, done_rdy,
    input  gnt_lo, gnt_hi, reject_lo, reject_hi, form_en, done_vld, done_bin
  );

  modport slave (
    input  req_lo, mat_lo, req_hi, mat_hi, bin_full, done_rdy,
    output gnt_lo, gnt_hi, reject_lo, reject_hi, form_en, done_vld, done_bin
  );

endinterface

// File: rtl/hormado_bin_decode.sv
// Maps a sealer's material code to its one-hot destination bin and flags
// codes that sealer may not produce (high sealer has no polyester bin).
module hormado_bin_decode
  import hormado_pkg::*;
(
  input  logic [2:0] mat,
  input  logic       size_hi,
  output logic       legal,
  output bin_t       bin
);

  // Material/size to bin lookup; illegal codes give legal=0 and no bin.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    legal = 1'b0;
    bin   = '0;
    case (mat)
      MAT_COT: begin
        legal = 1'b1;
        bin[size_hi ? BIN_HI_COT : BIN_LO_COT] = 1'b1;
      end
      MAT_POL: begin
        if (!size_hi) begin
          legal           = 1'b1;
          bin[BIN_LO_POL] = 1'b1;
        end
      end
      MAT_ACR: begin
        legal = 1'b1;
        bin[size_hi ? BIN_HI_ACR : BIN_LO_ACR] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hormado_arbiter.sv
// Shares one shaping station between the low and high sealers: arbitrates
// round-robin, times the shaping run and presents the finished pair's bin.
// Every output is decoded from registered state only.
module hormado_arbiter
  import hormado_pkg::*;
#(
  parameter int unsigned FORM_CYCLES = 6
) (
  input  logic     clk,
  input  logic     reset,
  hormado_if.slave bus
);

  localparam int unsigned   CW       = $clog2(FORM_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FORM_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_hi_q, last_hi_d;
  logic          side_hi_q, side_hi_d;
  bin_t          bin_q, bin_d;
  logic          rej_lo_q, rej_lo_d;
  logic          rej_hi_q, rej_hi_d;

  logic legal_lo, legal_hi;
  bin_t bin_lo, bin_hi;
  logic elig_lo, elig_hi;

  hormado_bin_decode u_dec_lo (
    .mat     (bus.mat_lo),
    .size_hi (1'b0),
    .legal   (legal_lo),
    .bin     (bin_lo)
  );

  hormado_bin_decode u_dec_hi (
    .mat     (bus.mat_hi),
    .size_hi (1'b1),
    .legal   (legal_hi),
    .bin     (bin_hi)
  );

  // A requester competes only with a legal material and a non-full target.
  assign elig_lo = bus.req_lo && legal_lo && ((bin_lo & bus.bin_full) == '0);
  assign elig_hi = bus.req_hi && legal_hi && ((bin_hi & bus.bin_full) == '0);

  // State register; asynchronous reset drops any in-flight pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_hi_q <= 1'b1;
      side_hi_q <= 1'b0;
      bin_q     <= '0;
      rej_lo_q  <= 1'b0;
      rej_hi_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_hi_q <= last_hi_d;
      side_hi_q <= side_hi_d;
      bin_q     <= bin_d;
      rej_lo_q  <= rej_lo_d;
      rej_hi_q  <= rej_hi_d;
    end
  end

  // Next-state: arbitration and rejects in IDLE, shaping timer in FORM,
  // output handshake in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_hi_d = last_hi_q;
    side_hi_d = side_hi_q;
    bin_d     = bin_q;
    rej_lo_d  = 1'b0;
    rej_hi_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Alternate with the previous pulse so a held bad request pulses every 2nd cycle.
        rej_lo_d = bus.req_lo && !legal_lo && !rej_lo_q;
        rej_hi_d = bus.req_hi && !legal_hi && !rej_hi_q;
        if (elig_lo && (!elig_hi || last_hi_q)) begin
          state_d   = ST_FORM;
          cnt_d     = '0;
          side_hi_d = 1'b0;
          bin_d     = bin_lo;
        end else if (elig_hi) begin
          state_d   = ST_FORM;
          cnt_d     = '0;
          side_hi_d = 1'b1;
          bin_d     = bin_hi;
        end
      end
      ST_FORM: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.done_rdy) begin
          state_d   = ST_IDLE;
          last_hi_d = side_hi_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant is the first shaping cycle of the latched side.
  assign bus.gnt_lo    = (state_q == ST_FORM) && (cnt_q == '0) && !side_hi_q;
  assign bus.gnt_hi    = (state_q == ST_FORM) && (cnt_q == '0) &&  side_hi_q;
  assign bus.reject_lo = rej_lo_q;
  assign bus.reject_hi = rej_hi_q;
  assign bus.form_en   = (state_q == ST_FORM);
  assign bus.done_vld  = (state_q == ST_DONE);
  assign bus.done_bin  = (state_q == ST_DONE) ? bin_q : '0;

endmodule
